// File: rtl/kernel_conv_sequencer.sv
// kernel_conv_sequencer
// Initiator side of the kernel accumulator handshake. Walks a SIZE x SIZE
// window in raster order (x fastest), fetches one coefficient/pixel pair per
// element from 1-cycle-latency read ports, hands it to the accumulator with a
// start/ready handshake, and captures the accumulator sum after the last
// element. CLEAR and WAIT_RDY are guarded by a timeout that raises err.
module kernel_conv_sequencer #(
    parameter logic [3:0] SIZE    = 4'd3,
    parameter int         TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       go,
    input  logic       abort,
    output logic [3:0] rd_x,
    output logic [3:0] rd_y,
    input  logic [7:0] kernel_data,
    input  logic [7:0] pixel_data,
    output logic       acc_clear,
    output logic       acc_start,
    output logic [7:0] acc_kernel_v,
    output logic [7:0] acc_pixel_v,
    input  logic       acc_ready,
    input  logic       acc_clear_flag,
    input  logic [7:0] acc_sum,
    output logic       busy,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       err
);

    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [3:0]    LAST = SIZE - 4'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_LOAD,
        S_FIRE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [3:0]    r_x;
    logic [3:0]    r_y;
    logic [7:0]    r_kernel_v;
    logic [7:0]    r_pixel_v;
    logic [7:0]    r_result;
    logic          r_err;
    logic [TW-1:0] r_timer;

    logic          w_last;
    logic          w_timeout;

    // Last element of the window and expiry of the CLEAR/WAIT_RDY timer.
    assign w_last    = (r_x == LAST) && (r_y == LAST);
    assign w_timeout = (r_timer == TMAX);

    // Control outputs are plain decodes of the state register, so abort or
    // reset removes them in the very next cycle.
    assign busy         = (r_state != S_IDLE);
    assign acc_clear    = (r_state == S_CLEAR);
    assign acc_start    = (r_state == S_FIRE);
    assign result_valid = (r_state == S_DONE);
    assign err          = r_err;
    assign rd_x         = r_x;
    assign rd_y         = r_y;
    assign acc_kernel_v = r_kernel_v;
    assign acc_pixel_v  = r_pixel_v;
    assign result       = r_result;

    // Sequencer FSM: window index, operand registers, timer and result capture.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_x        <= 4'd0;
            r_y        <= 4'd0;
            r_kernel_v <= 8'd0;
            r_pixel_v  <= 8'd0;
            r_result   <= 8'd0;
            r_err      <= 1'b0;
            r_timer    <= '0;
        end else begin
            r_err <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (go) begin
                            r_state <= S_CLEAR;
                            r_x     <= 4'd0;
                            r_y     <= 4'd0;
                            r_timer <= '0;
                        end
                    end
                    // acc_clear is held until the accumulator reports its
                    // reset cycle, so an ignored clear is simply retried.
                    S_CLEAR: begin
                        if (acc_clear_flag) begin
                            r_state <= S_FETCH;
                        end else if (w_timeout) begin
                            r_state <= S_IDLE;
                            r_err   <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    S_FETCH: begin
                        r_state <= S_LOAD;
                    end
                    // Read data for the address presented in FETCH arrives now.
                    S_LOAD: begin
                        r_kernel_v <= kernel_data;
                        r_pixel_v  <= pixel_data;
                        r_state    <= S_FIRE;
                    end
                    S_FIRE: begin
                        r_state <= S_WAIT;
                        r_timer <= '0;
                    end
                    // Operands stay untouched here: the accumulator samples
                    // them in the cycle after start.
                    S_WAIT: begin
                        if (acc_ready) begin
                            if (w_last) begin
                                // Capture on the way into DONE so result is
                                // already valid while result_valid is high.
                                r_result <= acc_sum;
                                r_state  <= S_DONE;
                            end else begin
                                if (r_x == LAST) begin
                                    r_x <= 4'd0;
                                    r_y <= r_y + 4'd1;
                                end else begin
                                    r_x <= r_x + 4'd1;
                                end
                                r_state <= S_FETCH;
                            end
                        end else if (w_timeout) begin
                            r_state <= S_IDLE;
                            r_err   <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
